// File: rtl/try_funct_pkg.sv
// Shared widths and the factorial helper for the try_funct datapath.
// Factorial arithmetic wraps modulo 2^32.
package try_funct_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 32;

  // Iterative product 1*2*...*n, truncated to RESW bits after every multiply.
  function automatic logic [RESW-1:0] factorial(input logic [OPW-1:0] n);
    logic [RESW-1:0] f;
    f = 32'd1;
    for (int i = 1; i < 16; i++) begin
      if (i[OPW-1:0] <= n) begin
        f = f * {28'd0, i[OPW-1:0]};
      end else begin
        f = f;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/try_funct_calc.sv
// Combinational n*n!/(2n+1) in 32-bit modulo arithmetic.
// The divisor is selected from 16 constants so each branch is a constant divide.
module try_funct_calc
  import try_funct_pkg::*;
(
  input  logic [OPW-1:0]  n,
  output logic [RESW-1:0] quot
);

  logic [RESW-1:0] fact_s;
  logic [RESW-1:0] prod_s;

  assign fact_s = factorial(n);
  assign prod_s = {28'd0, n} * fact_s;

  // Divide by 2n+1 using the constant divisor for each operand value.
  always_comb begin
    quot = 32'd0;
    case (n)
      4'd0:    quot = prod_s / 32'd1;
      4'd1:    quot = prod_s / 32'd3;
      4'd2:    quot = prod_s / 32'd5;
      4'd3:    quot = prod_s / 32'd7;
      4'd4:    quot = prod_s / 32'd9;
      4'd5:    quot = prod_s / 32'd11;
      4'd6:    quot = prod_s / 32'd13;
      4'd7:    quot = prod_s / 32'd15;
      4'd8:    quot = prod_s / 32'd17;
      4'd9:    quot = prod_s / 32'd19;
      4'd10:   quot = prod_s / 32'd21;
      4'd11:   quot = prod_s / 32'd23;
      4'd12:   quot = prod_s / 32'd25;
      4'd13:   quot = prod_s / 32'd27;
      4'd14:   quot = prod_s / 32'd29;
      4'd15:   quot = prod_s / 32'd31;
      default: quot = 32'd0;
    endcase
  end

endmodule

// File: rtl/try_funct.sv
// Registered n*n!/(2n+1): combinational calc stage feeding a 32-bit output
// register with synchronous active-high reset.
module try_funct
  import try_funct_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  n,
  output logic [RESW-1:0] result
);

  logic [RESW-1:0] quot_s;

  try_funct_calc u_calc (
    .n    (n),
    .quot (quot_s)
  );

  // Output register: clears on reset, otherwise loads the formula every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= 32'd0;
    end else begin
      result <= quot_s;
    end
  end

endmodule

// File: tb/tb_try_funct.sv
// Directed self-checking bench for try_funct with hand-computed expectations.
module tb_try_funct;

  logic        clk;
  logic        reset;
  logic [3:0]  n;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;

  try_funct dut (
    .clk    (clk),
    .reset  (reset),
    .n      (n),
    .result (result)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Independent 64-bit model of the wrapped formula.
  function automatic logic [31:0] model(input int v);
    longint unsigned f;
    longint unsigned p;
    f = 64'd1;
    for (int i = 2; i <= v; i++) f = (f * longint'(i)) & 64'hFFFF_FFFF;
    p = (longint'(v) * f) & 64'hFFFF_FFFF;
    return 32'(p / longint'(2 * v + 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    n     = 4'd5;
    step();
    check("reset_edge1", result, 32'd0);
    step();
    check("reset_edge2", result, 32'd0);
    reset = 1'b0;
    step();
    check("post_reset_n5", result, 32'd54);

    n = 4'd0; step(); check("sweep_n0", result, 32'd0);
    n = 4'd1; step(); check("sweep_n1", result, 32'd0);
    n = 4'd2; step(); check("sweep_n2", result, 32'd0);
    n = 4'd3; step(); check("sweep_n3", result, 32'd2);
    n = 4'd4; step(); check("sweep_n4", result, 32'd10);
    n = 4'd5; step(); check("sweep_n5", result, 32'd54);
    n = 4'd6; step(); check("sweep_n6", result, 32'd332);
    n = 4'd7; step(); check("sweep_n7", result, 32'd2352);

    n = 4'd12; step(); check("wrap_n12", result, 32'd58122076);
    n = 4'd13; step(); check("wrap_n13", result, 32'd134883669);
    n = 4'd14; step(); check("wrap_n14", result, 32'd25012577);
    check("model_n14", result, model(14));
    n = 4'd15; step(); check("wrap_n15", result, 32'd138543434);
    check("model_n15", result, model(15));

    n = 4'd7; step(); check("pre_mid_reset", result, 32'd2352);
    reset = 1'b1;
    step();
    check("mid_reset_clear", result, 32'd0);
    reset = 1'b0;
    step();
    check("mid_reset_restore", result, 32'd2352);

    n = 4'd3;
    #10;
    n = 4'd4;
    step();
    check("between_edges", result, 32'd10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
